pss_correlator_peak_detector: RTL and testbench

// - Sliding complex cross-correlation of the decimated baseband stream against a local PSS replica.
// - Magnitude output, plus a one-cycle peak pulse that marks PSS timing.
// - Sits between the CIC decimator and the sync-wait counter that starts the FFT / SSB demodulator.

---
 rtl/pss_pkg.sv | 14 +
 rtl/pss_correlator_peak_detector_if.sv | 10 +
 rtl/pss_correlator_peak_detector_peak_window.sv | 44 ++++
 rtl/pss_correlator_peak_detector.sv | 118 +++++++++++
 tb/tb_pss_correlator_peak_detector.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/pss_pkg.sv
// Shared definitions for the PSS correlator / peak detector slice.
package pss_pkg;

  localparam int ALGO_SQUARE  = 0;
  localparam int ALGO_ABS     = 1;
  localparam int CORR_LATENCY = 3;

  // Complex sample at the default 16-bit component width, imag in the upper half.
  typedef struct packed {
    logic signed [15:0] im;
    logic signed [15:0] re;
  } cplx16_t;

endpackage

// File: rtl/pss_correlator_peak_detector_if.sv
// Valid-only stream (no backpressure) used for samples in and magnitudes out.
interface pss_correlator_peak_detector_if #(
  parameter int DW = 32
);
  logic [DW-1:0] tdata;
  logic          tvalid;

  modport master (output tdata, output tvalid);
  modport slave  (input  tdata, input  tvalid);
endinterface

// File: rtl/pss_correlator_peak_detector_peak_window.sv
// Peak detector: new magnitude beats the sum of the last WINDOW_LEN magnitudes.
module pss_peak_window #(
  parameter int DW         = 32,
  parameter int WINDOW_LEN = 8
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          mag_valid,
  input  logic [DW-1:0] mag,
  output logic          peak
);
  localparam int PTR_W  = $clog2(WINDOW_LEN);
  localparam int SUM_W  = DW + PTR_W;
  localparam int FILL_W = $clog2(WINDOW_LEN + 1);

  logic [DW-1:0]     hist [WINDOW_LEN];
  logic [PTR_W-1:0]  ptr;
  logic [SUM_W-1:0]  sum;
  logic [FILL_W-1:0] fill;
  logic              full;

  assign full = (fill == FILL_W'(WINDOW_LEN));

  // The oldest slot is subtracted from the sum on every push, so unfilled slots must read 0.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < WINDOW_LEN; i++) hist[i] <= '0;
      ptr  <= '0;
      sum  <= '0;
      fill <= '0;
      peak <= 1'b0;
    end else begin
      peak <= 1'b0;
      if (mag_valid) begin
        peak      <= full && (SUM_W'(mag) > sum);
        hist[ptr] <= mag;
        sum       <= sum + SUM_W'(mag) - SUM_W'(hist[ptr]);
        ptr       <= ptr + 1'b1;
        if (!full) fill <= fill + 1'b1;
      end
    end
  end

endmodule

// File: rtl/pss_correlator_peak_detector.sv
// Sliding complex correlation against a fixed PSS replica, magnitude, and peak pulse.
module pss_correlator_peak_detector
  import pss_pkg::*;
#(
  parameter int                        IN_DW      = 32,
  parameter int                        OUT_DW     = 32,
  parameter int                        TAP_DW     = 32,
  parameter int                        PSS_LEN    = 128,
  parameter logic [PSS_LEN*TAP_DW-1:0] PSS_LOCAL  = '0,
  parameter int                        ALGO       = ALGO_ABS,
  parameter int                        WINDOW_LEN = 8
) (
  input  logic                             clk_i,
  input  logic                             reset_i,
  pss_correlator_peak_detector_if.slave    s_axis_in,
  pss_correlator_peak_detector_if.master   m_axis_correlator,
  output logic                             peak_detected_o
);
  localparam int XW     = IN_DW / 2;
  localparam int TW     = TAP_DW / 2;
  localparam int P1_W   = XW + TW + 1;
  localparam int ACC_W  = P1_W + $clog2(PSS_LEN);
  localparam int SQ1_W  = 2 * ACC_W;
  localparam int MAG_W  = (SQ1_W + 1 > OUT_DW) ? SQ1_W + 1 : OUT_DW + 1;

  logic [IN_DW-1:0]         dline [PSS_LEN];
  logic [CORR_LATENCY-1:0]  vld_sr;
  logic signed [P1_W-1:0]   prod_re [PSS_LEN];
  logic signed [P1_W-1:0]   prod_im [PSS_LEN];
  logic signed [ACC_W-1:0]  sum_re, sum_im, acc_re, acc_im;
  logic [ACC_W-1:0]         abs_re, abs_im;
  logic [MAG_W-1:0]         mag_full;
  logic [OUT_DW-1:0]        mag_sat, mag_q;

  // NOTE: the delay line is reset, not left undefined, because not-yet-received samples must count as 0.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int k = 0; k < PSS_LEN; k++) dline[k] <= '0;
      vld_sr <= '0;
    end else begin
      vld_sr <= {vld_sr[CORR_LATENCY-2:0], s_axis_in.tvalid};
      if (s_axis_in.tvalid) begin
        dline[0] <= s_axis_in.tdata;
        for (int k = 1; k < PSS_LEN; k++) dline[k] <= dline[k-1];
      end
    end
  end

  // x * conj(t) = (xr*tr + xi*ti) + j(xi*tr - xr*ti)
  for (genvar k = 0; k < PSS_LEN; k++) begin : g_tap
    logic signed [XW-1:0] xr, xi;
    logic signed [TW-1:0] tr, ti;
    assign xr = dline[k][XW-1:0];
    assign xi = dline[k][IN_DW-1:XW];
    assign tr = PSS_LOCAL[k*TAP_DW +: TW];
    assign ti = PSS_LOCAL[k*TAP_DW+TW +: TW];
    assign prod_re[k] = P1_W'(xr) * P1_W'(tr) + P1_W'(xi) * P1_W'(ti);
    assign prod_im[k] = P1_W'(xi) * P1_W'(tr) - P1_W'(xr) * P1_W'(ti);
  end

  // NOTE: blocking assignments here are deliberate: each iteration must see the previous partial sum.
  always_comb begin
    sum_re = '0;
    sum_im = '0;
    for (int k = 0; k < PSS_LEN; k++) begin
      sum_re = sum_re + ACC_W'(prod_re[k]);
      sum_im = sum_im + ACC_W'(prod_im[k]);
    end
  end

  // |min| fits the unsigned range, so negation then reinterpretation is exact.
  assign abs_re = acc_re[ACC_W-1] ? ACC_W'(-acc_re) : ACC_W'(acc_re);
  assign abs_im = acc_im[ACC_W-1] ? ACC_W'(-acc_im) : ACC_W'(acc_im);

  if (ALGO == ALGO_SQUARE) begin : g_square
    logic [SQ1_W-1:0] sq_re, sq_im;
    assign sq_re    = SQ1_W'(abs_re) * SQ1_W'(abs_re);
    assign sq_im    = SQ1_W'(abs_im) * SQ1_W'(abs_im);
    assign mag_full = MAG_W'(sq_re) + MAG_W'(sq_im);
  end else begin : g_abs
    assign mag_full = MAG_W'(abs_re) + MAG_W'(abs_im);
  end

  // NOTE: the default assignment first keeps this combinational block from inferring a latch.
  always_comb begin
    mag_sat = mag_full[OUT_DW-1:0];
    if (|mag_full[MAG_W-1:OUT_DW]) mag_sat = '1;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      acc_re <= '0;
      acc_im <= '0;
      mag_q  <= '0;
    end else begin
      if (vld_sr[0]) begin
        acc_re <= sum_re;
        acc_im <= sum_im;
      end
      if (vld_sr[1]) mag_q <= mag_sat;
    end
  end

  assign m_axis_correlator.tdata  = mag_q;
  assign m_axis_correlator.tvalid = vld_sr[CORR_LATENCY-1];

  pss_peak_window #(
    .DW         (OUT_DW),
    .WINDOW_LEN (WINDOW_LEN)
  ) u_peak_window (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .mag_valid (vld_sr[CORR_LATENCY-1]),
    .mag       (mag_q),
    .peak      (peak_detected_o)
  );

endmodule

// File: tb/tb_pss_correlator_peak_detector.sv
// Self-checking bench: four correlator configurations against a queue-based reference model.
module tb_pss_correlator_peak_detector;
  import pss_pkg::*;

  localparam int ND   = 4;
  localparam int MAXP = 4096;
  localparam logic [127:0] TAPS_ONE = {4{32'h0000_0001}};
  localparam logic [127:0] TAPS_MIX = {32'h0001_0000, 32'hFFFF_0002, 32'h0001_FFFD, 32'h0002_0001};

  logic clk_i = 1'b0;
  logic reset_i;
  always #5 clk_i = ~clk_i;

  pss_correlator_peak_detector_if #(.DW(32)) s_if ();
  pss_correlator_peak_detector_if #(.DW(32)) o0 ();
  pss_correlator_peak_detector_if #(.DW(32)) o1 ();
  pss_correlator_peak_detector_if #(.DW(8))  o2 ();
  pss_correlator_peak_detector_if #(.DW(32)) o3 ();
  logic pk [ND];

  pss_correlator_peak_detector #(.IN_DW(32), .OUT_DW(32), .TAP_DW(32), .PSS_LEN(4),
    .PSS_LOCAL(TAPS_ONE), .ALGO(ALGO_SQUARE), .WINDOW_LEN(4)) dut_sq (
    .clk_i(clk_i), .reset_i(reset_i), .s_axis_in(s_if), .m_axis_correlator(o0), .peak_detected_o(pk[0]));
  pss_correlator_peak_detector #(.IN_DW(32), .OUT_DW(32), .TAP_DW(32), .PSS_LEN(4),
    .PSS_LOCAL(TAPS_ONE), .ALGO(ALGO_ABS), .WINDOW_LEN(4)) dut_abs (
    .clk_i(clk_i), .reset_i(reset_i), .s_axis_in(s_if), .m_axis_correlator(o1), .peak_detected_o(pk[1]));
  pss_correlator_peak_detector #(.IN_DW(32), .OUT_DW(8), .TAP_DW(32), .PSS_LEN(4),
    .PSS_LOCAL(TAPS_ONE), .ALGO(ALGO_SQUARE), .WINDOW_LEN(4)) dut_sat (
    .clk_i(clk_i), .reset_i(reset_i), .s_axis_in(s_if), .m_axis_correlator(o2), .peak_detected_o(pk[2]));
  pss_correlator_peak_detector #(.IN_DW(32), .OUT_DW(32), .TAP_DW(32), .PSS_LEN(4),
    .PSS_LOCAL(TAPS_MIX), .ALGO(ALGO_SQUARE), .WINDOW_LEN(4)) dut_mix (
    .clk_i(clk_i), .reset_i(reset_i), .s_axis_in(s_if), .m_axis_correlator(o3), .peak_detected_o(pk[3]));

  logic [31:0] obs_data [ND];
  logic        obs_vld  [ND];
  assign obs_data[0] = o0.tdata;
  assign obs_data[1] = o1.tdata;
  assign obs_data[2] = {24'd0, o2.tdata};
  assign obs_data[3] = o3.tdata;
  assign obs_vld[0]  = o0.tvalid;
  assign obs_vld[1]  = o1.tvalid;
  assign obs_vld[2]  = o2.tvalid;
  assign obs_vld[3]  = o3.tvalid;

  // Reference model state: configuration, sample history, magnitude windows, expectations per cycle.
  int     tap_re [ND][4];
  int     tap_im [ND][4];
  int     algo_of [ND];
  int     odw [ND];
  int     xq_re [$];
  int     xq_im [$];
  longint win [ND][$];
  bit     exp_vld [MAXP];
  longint exp_mag [ND][MAXP];
  bit     exp_peak [ND][MAXP];
  longint seq [ND][$];
  int     peaks [ND];
  longint model_seq [$];
  int     model_peaks;
  int     cyc;
  int     n_checks, n_pass, n_fail;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    xq_re.delete();
    xq_im.delete();
    model_seq.delete();
    model_peaks = 0;
    for (int d = 0; d < ND; d++) begin
      win[d].delete();
      seq[d].delete();
      peaks[d] = 0;
      for (int i = 0; i < MAXP; i++) begin
        exp_mag[d][i]  = 0;
        exp_peak[d][i] = 1'b0;
      end
    end
    for (int i = 0; i < MAXP; i++) exp_vld[i] = 1'b0;
  endtask

  // Correlation straight from the definition: sum over the newest samples of x[n-k]*conj(tap[k]).
  task automatic model_accept(input int xr, input int xi);
    longint re, im, mag, sat, s;
    bit     p;
    xq_re.push_front(xr);
    xq_im.push_front(xi);
    if (xq_re.size() > 4) begin
      void'(xq_re.pop_back());
      void'(xq_im.pop_back());
    end
    for (int d = 0; d < ND; d++) begin
      re = 0;
      im = 0;
      for (int k = 0; k < xq_re.size(); k++) begin
        re += longint'(xq_re[k]) * tap_re[d][k] + longint'(xq_im[k]) * tap_im[d][k];
        im += longint'(xq_im[k]) * tap_re[d][k] - longint'(xq_re[k]) * tap_im[d][k];
      end
      if (algo_of[d] == ALGO_ABS) mag = (re < 0 ? -re : re) + (im < 0 ? -im : im);
      else mag = re * re + im * im;
      sat = (longint'(1) << odw[d]) - 1;
      if (mag > sat) mag = sat;
      s = 0;
      foreach (win[d][i]) s += win[d][i];
      p = (win[d].size() == 4) && (mag > s);
      win[d].push_back(mag);
      if (win[d].size() > 4) void'(win[d].pop_front());
      exp_mag[d][cyc+2]  = mag;
      exp_peak[d][cyc+3] = p;
      if (d == 0) begin
        model_seq.push_back(mag);
        model_peaks += int'(p);
      end
    end
    exp_vld[cyc+2] = 1'b1;
  endtask

  task automatic check_outputs();
    for (int d = 0; d < ND; d++) begin
      check($sformatf("d%0d_tvalid@%0d", d, cyc), 64'(obs_vld[d]), 64'(exp_vld[cyc]));
      if (exp_vld[cyc]) check($sformatf("d%0d_tdata@%0d", d, cyc), 64'(obs_data[d]), exp_mag[d][cyc]);
      check($sformatf("d%0d_peak@%0d", d, cyc), 64'(pk[d]), 64'(exp_peak[d][cyc]));
      if (obs_vld[d]) seq[d].push_back(longint'(obs_data[d]));
      if (pk[d]) peaks[d]++;
    end
  endtask

  task automatic check_reset_state(input string tag);
    for (int d = 0; d < ND; d++) begin
      check($sformatf("%s_d%0d_tvalid", tag, d), 64'(obs_vld[d]), 64'd0);
      check($sformatf("%s_d%0d_tdata", tag, d), 64'(obs_data[d]), 64'd0);
      check($sformatf("%s_d%0d_peak", tag, d), 64'(pk[d]), 64'd0);
    end
  endtask

  task automatic step(input bit v, input int re, input int im);
    cplx16_t s;
    s.re = 16'(re);
    s.im = 16'(im);
    s_if.tvalid = v;
    s_if.tdata  = s;
    @(posedge clk_i);
    cyc++;
    if (v) model_accept(re, im);
    @(negedge clk_i);
    check_outputs();
  endtask

  // Called at a falling edge; mid_cycle moves the assertion away from any edge to show it is asynchronous.
  task automatic apply_reset(input string tag, input bit mid_cycle);
    if (mid_cycle) #2;
    s_if.tvalid = 1'b0;
    reset_i = 1'b1;
    #1;
    check_reset_state(tag);
    clear_model();
    @(posedge clk_i);
    cyc++;
    @(negedge clk_i);
    check_outputs();
    reset_i = 1'b0;
  endtask

  function automatic int rnd_comp(input int kind);
    case (kind)
      0, 1, 2, 3, 4, 5: return int'($urandom_range(0, 14)) - 7;
      6, 7:             return int'($urandom_range(0, 4000)) - 2000;
      8:                return int'($urandom_range(0, 65535)) - 32768;
      default:          return 0;
    endcase
  endfunction

  int     pat [17] = '{0, 0, 0, 0, 0, 50, 0, 0, 0, 0, 3, 200, 0, 0, 0, 0, 0};
  longint want_const [6] = '{1, 4, 9, 16, 16, 16};
  longint dense_seq [$];
  int     dense_peaks;

  initial begin
    n_checks = 0; n_pass = 0; n_fail = 0; cyc = 0;
    for (int d = 0; d < ND; d++) begin
      for (int k = 0; k < 4; k++) begin
        tap_re[d][k] = 1;
        tap_im[d][k] = 0;
      end
      algo_of[d] = ALGO_SQUARE;
      odw[d]     = 32;
    end
    algo_of[1] = ALGO_ABS;
    odw[2]     = 8;
    tap_re[3] = '{1, -3, 2, 0};
    tap_im[3] = '{2, 1, -1, 1};

    reset_i = 1'b1;
    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    clear_model();
    @(negedge clk_i);
    check_reset_state("por");
    reset_i = 1'b0;

    // Constant 1+0j: squared magnitudes ramp 1, 4, 9, 16 then hold.
    repeat (6) step(1'b1, 1, 0);
    repeat (4) step(1'b0, 0, 0);
    check("const_count", 64'(seq[0].size()), 64'd6);
    for (int i = 0; i < 6; i++) check($sformatf("const_%0d", i), seq[0][i], want_const[i]);

    // 0+1j four times through the |re|+|im| variant.
    apply_reset("rst_abs", 1'b0);
    repeat (4) step(1'b1, 0, 1);
    repeat (4) step(1'b0, 0, 0);
    check("abs_4th", seq[1][3], 64'd4);

    // Impulse after a zero-filled window.
    apply_reset("rst_peak", 1'b0);
    repeat (4) step(1'b1, 0, 0);
    step(1'b1, 100, 0);
    step(1'b1, 0, 0);
    repeat (5) step(1'b0, 0, 0);
    check("peak_mag", seq[0][4], 64'd10000);
    check("peak_sat_mag", seq[2][4], 64'd255);
    check("peak_count", 64'(peaks[0]), 64'd1);

    // Impulse too early for the window to be full.
    apply_reset("rst_early", 1'b0);
    step(1'b1, 0, 0);
    step(1'b1, 500, 0);
    repeat (6) step(1'b1, 0, 0);
    repeat (5) step(1'b0, 0, 0);
    check("early_no_peak", 64'(peaks[0]), 64'd0);

    // Dense run, then the same samples with two idle cycles between each.
    apply_reset("rst_dense", 1'b0);
    foreach (pat[i]) step(1'b1, pat[i], 0);
    repeat (5) step(1'b0, 0, 0);
    dense_seq   = model_seq;
    dense_peaks = model_peaks;
    apply_reset("rst_gap", 1'b0);
    foreach (pat[i]) begin
      step(1'b1, pat[i], 0);
      repeat (2) step(1'b0, 0, 0);
    end
    repeat (5) step(1'b0, 0, 0);
    check("gap_count", 64'(seq[0].size()), 64'(dense_seq.size()));
    for (int i = 0; i < dense_seq.size(); i++) check($sformatf("gap_val_%0d", i), seq[0][i], dense_seq[i]);
    check("gap_peaks", 64'(peaks[0]), 64'(dense_peaks));

    // Full-scale input into the 8-bit output build.
    apply_reset("rst_sat", 1'b0);
    repeat (6) step(1'b1, -32768, -32768);
    repeat (4) step(1'b0, 0, 0);
    check("sat_count", 64'(seq[2].size()), 64'd6);
    foreach (seq[2][i]) check($sformatf("sat_%0d", i), seq[2][i], 64'd255);

    // Random traffic with occasional mid-stream resets.
    apply_reset("rst_rand", 1'b0);
    for (int i = 0; i < 400; i++) begin
      int kind;
      if (i == 200 || $urandom_range(0, 149) == 0) apply_reset("rst_mid", 1'b1);
      kind = int'($urandom_range(0, 9));
      step($urandom_range(0, 3) != 0, rnd_comp(kind), rnd_comp(kind));
    end
    repeat (5) step(1'b0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
